// File: rtl/rv_pkg.sv
// Shared RV32I-subset decode definitions: opcodes, ALU/write-back encodings
// and the decoded control bundle carried from decode into execute.
package rv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU_ADDI serves addi and jal; ALU_MEM serves lw and jalr.
    typedef enum logic [4:0] {
        ALU_NONE = 5'b00000,
        ALU_AND  = 5'b00100,
        ALU_OR   = 5'b00101,
        ALU_XOR  = 5'b00110,
        ALU_SRL  = 5'b01001,
        ALU_ADDI = 5'b01100,
        ALU_ADD  = 5'b01101,
        ALU_SUB  = 5'b01110,
        ALU_BR   = 5'b10001,
        ALU_MEM  = 5'b10100,
        ALU_ST   = 5'b10101
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    // uses_rs1/uses_rs2 mark which source registers the format actually reads.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_op_e    alu_op;
        logic       alu_src1;
        logic       alu_src2;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        wb_sel_e    wb_sel;
        logic       is_branch;
        logic       is_jump;
        logic [2:0] br_type;
        logic       illegal;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// A beat moves on a rising clk edge where valid && ready are both high; a producer
// keeps valid and payload stable while valid && !ready, and valid never waits on ready.
interface rv_decode_stage_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_alu_op;
    logic            out_alu_src1;
    logic            out_alu_src2;
    logic            out_reg_we;
    logic            out_mem_we;
    logic            out_mem_re;
    logic [1:0]      out_wb_sel;
    logic            out_is_branch;
    logic            out_is_jump;
    logic [2:0]      out_br_type;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_op, out_alu_src1, out_alu_src2, out_reg_we, out_mem_we,
               out_mem_re, out_wb_sel, out_is_branch, out_is_jump, out_br_type,
               out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_op, out_alu_src1, out_alu_src2, out_reg_we, out_mem_we,
               out_mem_re, out_wb_sel, out_is_branch, out_is_jump, out_br_type,
               out_illegal
    );

endinterface

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I-subset decoder: instruction word to control bundle
// plus sign-extended immediate.
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm32;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        ctrl     = '0;
        imm32    = '0;
        ctrl.rs1 = inst[19:15];
        ctrl.rs2 = inst[24:20];
        ctrl.rd  = inst[11:7];
        case (opcode)
            OP_BRANCH: begin
                ctrl.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
                ctrl.alu_op    = ALU_BR;
                imm32          = imm_b;
                ctrl.alu_src1  = 1'b1;
                ctrl.alu_src2  = 1'b1;
                ctrl.is_branch = 1'b1;
                ctrl.br_type   = funct3;
                ctrl.uses_rs1  = 1'b1;
                ctrl.uses_rs2  = 1'b1;
            end
            OP_LOAD: begin
                ctrl.illegal  = (funct3 != 3'b010);
                ctrl.alu_op   = ALU_MEM;
                imm32         = imm_i;
                ctrl.alu_src2 = 1'b1;
                ctrl.mem_re   = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                ctrl.reg_we   = 1'b1;
                ctrl.uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl.illegal  = (funct3 != 3'b010);
                ctrl.alu_op   = ALU_ST;
                imm32         = imm_s;
                ctrl.alu_src2 = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl.illegal  = (funct3 != 3'b000);
                ctrl.alu_op   = ALU_ADDI;
                imm32         = imm_i;
                ctrl.alu_src2 = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.uses_rs1 = 1'b1;
            end
            OP_REG: begin
                ctrl.reg_we   = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: ctrl.alu_op = ALU_ADD;
                    10'b0100000_000: ctrl.alu_op = ALU_SUB;
                    10'b0000000_100: ctrl.alu_op = ALU_XOR;
                    10'b0000000_101: ctrl.alu_op = ALU_SRL;
                    10'b0000000_110: ctrl.alu_op = ALU_OR;
                    10'b0000000_111: ctrl.alu_op = ALU_AND;
                    default:         ctrl.illegal = 1'b1;
                endcase
            end
            OP_JALR: begin
                ctrl.illegal  = (funct3 != 3'b000);
                ctrl.alu_op   = ALU_MEM;
                imm32         = imm_i;
                ctrl.alu_src2 = 1'b1;
                ctrl.is_jump  = 1'b1;
                ctrl.wb_sel   = WB_PC4;
                ctrl.reg_we   = 1'b1;
                ctrl.uses_rs1 = 1'b1;
            end
            OP_JAL: begin
                ctrl.alu_op   = ALU_ADDI;
                imm32         = imm_j;
                ctrl.alu_src1 = 1'b1;
                ctrl.alu_src2 = 1'b1;
                ctrl.is_jump  = 1'b1;
                ctrl.wb_sel   = WB_PC4;
                ctrl.reg_we   = 1'b1;
            end
            OP_LUI: begin
                imm32         = imm_u;
                ctrl.wb_sel   = WB_IMM;
                ctrl.reg_we   = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        // Unsupported encodings still issue, but with every side effect scrubbed.
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.rs1     = inst[19:15];
            ctrl.rs2     = inst[24:20];
            ctrl.rd      = inst[11:7];
            ctrl.illegal = 1'b1;
            imm32        = '0;
        end
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Decode pipeline stage: optional input skid, registered decoded bundle,
// load-use bubble insertion and synchronous flush on redirect.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit SKID_EN   = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    rv_decode_stage_if.slave  bus
);

    logic            skid_valid;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_pc;

    logic            out_valid;
    ctrl_t           out_ctrl;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;

    logic            src_valid;
    logic [31:0]     src_inst;
    logic [XLEN-1:0] src_pc;
    ctrl_t           src_ctrl;
    logic [XLEN-1:0] src_imm;

    logic advance, rs1_hit, rs2_hit, hazard, take_src, port_fire;

    // A parked skid entry always wins so program order is kept.
    assign src_valid = skid_valid || bus.in_valid;
    assign src_inst  = skid_valid ? skid_inst : bus.in_inst;
    assign src_pc    = skid_valid ? skid_pc   : bus.in_pc;

    rv_decode_comb #(.XLEN(XLEN)) u_decode (
        .inst (src_inst),
        .ctrl (src_ctrl),
        .imm  (src_imm)
    );

    assign rs1_hit = src_ctrl.uses_rs1 && (src_ctrl.rs1 != 5'd0) && (src_ctrl.rs1 == out_ctrl.rd);
    assign rs2_hit = src_ctrl.uses_rs2 && (src_ctrl.rs2 != 5'd0) && (src_ctrl.rs2 == out_ctrl.rd);
    assign hazard  = HAZARD_EN && src_valid && out_valid && out_ctrl.mem_re && (rs1_hit || rs2_hit);

    assign advance   = !out_valid || bus.out_ready;
    assign take_src  = advance && src_valid && !hazard;
    assign port_fire = bus.in_valid && bus.in_ready;

    assign bus.in_ready = SKID_EN ? !skid_valid : (advance && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            // On a hazard the output drains into a bubble while the source waits.
            if (advance) begin
                out_valid <= take_src;
                if (take_src) begin
                    out_ctrl <= src_ctrl;
                    out_imm  <= src_imm;
                    out_pc   <= src_pc;
                end
            end
            if (SKID_EN) begin
                if (skid_valid) begin
                    if (take_src) skid_valid <= 1'b0;
                end else if (port_fire && !take_src) begin
                    skid_valid <= 1'b1;
                    skid_inst  <= bus.in_inst;
                    skid_pc    <= bus.in_pc;
                end
            end
        end
    end

    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = out_pc;
    assign bus.out_rs1       = out_ctrl.rs1;
    assign bus.out_rs2       = out_ctrl.rs2;
    assign bus.out_rd        = out_ctrl.rd;
    assign bus.out_imm       = out_imm;
    assign bus.out_alu_op    = out_ctrl.alu_op;
    assign bus.out_alu_src1  = out_ctrl.alu_src1;
    assign bus.out_alu_src2  = out_ctrl.alu_src2;
    assign bus.out_reg_we    = out_ctrl.reg_we;
    assign bus.out_mem_we    = out_ctrl.mem_we;
    assign bus.out_mem_re    = out_ctrl.mem_re;
    assign bus.out_wb_sel    = out_ctrl.wb_sel;
    assign bus.out_is_branch = out_ctrl.is_branch;
    assign bus.out_is_jump   = out_ctrl.is_jump;
    assign bus.out_br_type   = out_ctrl.br_type;
    assign bus.out_illegal   = out_ctrl.illegal;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Pipelined RV32I-subset instruction decode stage for the pipelined core; sits between the fetch stage and the execute stage.
- Decodes one instruction per cycle into a registered control/immediate bundle, using valid/ready handshakes on both sides.
- Optional skid buffer on the input.
- Built-in load-use interlock and synchronous flush.
- Branch resolution moves out of decode: emits br_type only; compare/PC select happens in EX.

Parameters:
- XLEN, 32, datapath width; immediates sign-extended to XLEN, pc width = XLEN.
- SKID_EN, 1, 1 = one-entry input skid buffer (in_ready registered); 0 = in_ready combinational.
- HAZARD_EN, 1, 1 = insert load-use bubble; 0 = no interlock (forwarding handled elsewhere).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill skid and output register contents (branch/jump redirect)
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  decode accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts bundle
- out_pc  out  XLEN  PC of decoded instruction
- out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], [24:20], [11:7]
- out_imm  out  XLEN  sign-extended immediate
- out_alu_op  out  5  ALU operation code
- out_alu_src1  out  1  0 = rs1, 1 = PC
- out_alu_src2  out  1  0 = rs2, 1 = imm
- out_reg_we  out  1  register-file write
- out_mem_we  out  1  store
- out_mem_re  out  1  load
- out_wb_sel  out  2  00 = ALU, 01 = mem, 10 = PC+4, 11 = imm
- out_is_branch  out  1  conditional branch
- out_is_jump  out  1  jal/jalr
- out_br_type  out  3  funct3 of branch
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst high at edge): out_valid = 0, skid empty, every out_* bundle field = 0. First cycle after reset: in_ready = 1.
- Latency: an accepted instruction appears on out_* exactly 1 cycle later when there is no stall.
- Output register loads when (!out_valid || out_ready) and a source is valid. Otherwise it holds all fields stable while out_valid & !out_ready.
- Source: skid entry if skid valid, else the input port.
- SKID_EN=1:
  - Input accepted while skid empty but the source cannot advance (output full or hazard) → captured into skid.
  - in_ready = !skid_valid.
  - Skid drains before the port is used again.
  - Strict order; no loss, no duplication.
- SKID_EN=0: in_ready = advance && !hazard (combinational).
- Load-use hazard (HAZARD_EN=1):
  - Condition: source reads rs1 or rs2 (per format); register ≠ x0; it equals out_rd; out_valid; out_mem_re.
  - Response: when the output transfers, load a bubble (out_valid = 0) and hold the source.
  - Dependent instruction issues on the next advance. Exactly one bubble per load-use pair.
- Decode table (alu_op; other fields inactive = 0):
  - beq/bne/blt/bge/bltu/bgeu (1100011; funct3 000,001,100,101,110,111): alu_op 10001; imm_B; src1 = PC; src2 = imm; is_branch; br_type = funct3; reg_we 0.
  - lw (0000011, f3 010): alu_op 10100; imm_I; src2 = imm; mem_re; wb_sel 01; reg_we.
  - sw (0100011, f3 010): alu_op 10101; imm_S; src2 = imm; mem_we; reg_we 0.
  - addi (0010011, f3 000): alu_op 01100; imm_I; src2 = imm; reg_we.
  - R-type (0110011), src2 = rs2, reg_we:
    - add (funct7 0000000, f3 000): alu_op 01101
    - sub (funct7 0100000, f3 000): alu_op 01110
    - xor (f3 100): alu_op 00110
    - srl (f3 101): alu_op 01001
    - or (f3 110): alu_op 00101
    - and (f3 111): alu_op 00100
  - jalr (1100111, f3 000): alu_op 10100; imm_I; src2 = imm; is_jump; wb_sel 10; reg_we.
  - jal (1101111): alu_op 01100; imm_J; src1 = PC; src2 = imm; is_jump; wb_sel 10; reg_we.
  - lui (0110111): alu_op 0; imm_U; wb_sel 11; reg_we.
  - Anything else: illegal = 1; alu_op 0; reg_we 0; mem_we 0; mem_re 0; is_branch 0; is_jump 0; still issued with out_valid.
- Flush:
  - Next edge: out_valid = 0, skid cleared; input offered that cycle is dropped (in_ready still reported).
  - Priority: rst > flush > normal.
  - Flush with out_ready = 0 still clears out_valid.
- out_* fields are don't-care while out_valid = 0, except after reset, when all are 0.

Decomposition:
- Shared package rv_pkg:
  - Opcode constants.
  - ALU_OP codes.
  - WB_SEL encodings.
  - Decoded-bundle struct typedef.
- One combinational sub-module, rv_decode_comb (inst → bundle, parameter XLEN).
- Sequential logic stays in rv_decode_stage: skid, output register, hazard check.

Test Plan:
- rst, then addi x1,x2,5 (0x00510093) at in_pc 0x100 → one cycle later: out_valid = 1, alu_op 01100, imm 5, rs1 2, rd 1, reg_we 1, out_pc 0x100.
- lw x3,0(x1) (0x0000A183) then add x4,x3,x5 (0x00518233), out_ready = 1 → lw out, then one bubble cycle, then add with alu_op 01101, src2 0.
- bne x1,x2,-4 (0xFE209EE3) → imm 0xFFFFFFFC, is_branch 1, br_type 001, src1 1, reg_we 0.
- Stream of 6 addi; out_ready low for 3 cycles mid-stream (SKID_EN=1) → in_ready drops one cycle after stall; all 6 out in order, none duplicated; stalled bundle stable.
- Flush while skid and output full → next cycle out_valid = 0; the instruction after the flush issues normally.
- Instruction 0xFFFFFFFF → out_valid 1, illegal 1, reg_we 0, mem_we 0.
